memory_responder: RTL
=====================

Name: memory_responder

Overview:
- Data-memory responder: the target end of the core's memory-access interface. Serves fetches, loads and stores.
- Accepts one request per handshake, carrying address, write enable, write data and memory_funct3.
- Inserts a configurable number of wait states, then commits a store or returns load data with a one-cycle response pulse.
- Byte-lane selection and alignment checking are done here; sign/zero extension of load data remains with the requester.

Parameters:
- ADDR_WIDTH, 10, word-index width; array holds 2**ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 0, extra cycles between request capture and response (0..15).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  responder can capture a request
- memory_write_en  input  1  1 = store, 0 = load/fetch
- memory_funct3  input  3  access size: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned
- memory_read_address  input  32  byte address for loads/fetches
- memory_write_address  input  32  byte address for stores
- memory_write  input  32  store data; only the low 8/16/32 bits are used per funct3
- resp_valid  output  1  one-cycle response pulse
- memory_read_value  output  32  load data, addressed byte/half shifted to bit 0, upper bits zero
- resp_error  output  1  valid with resp_valid; request rejected

Behaviour:
- Reset: state IDLE, req_ready=1, resp_valid=0, memory_read_value=0, resp_error=0. Array contents are not cleared.
- Reset during WAIT or RESP abandons the pending request. A pending store is not committed if reset is sampled on or before its commit edge.
- Capture: on a rising edge with req_valid && req_ready, register write_en, funct3, data and the selected address.
  - Address is memory_write_address when write_en=1, else memory_read_address.
- FSM states:
  - IDLE: req_ready=1. On capture, go to WAIT if WAIT_CYCLES>0, else RESP.
  - WAIT: req_ready=0. 4-bit counter loaded with WAIT_CYCLES-1 on capture, decrements each cycle. At 0 -> RESP.
  - RESP: resp_valid=1, req_ready=0, for exactly one cycle, then IDLE.
- Latency: with WAIT_CYCLES=N, resp_valid is high in the (N+1)th cycle after the capture edge.
- Back-to-back: requests are accepted every N+2 cycles. No request is accepted in RESP.
- Commit: array read and store byte-lane write both occur on the edge entering RESP. The response data reflects pre-store contents, which is irrelevant for stores.
  - A load following a store to the same word returns the new data.
- Word index = addr[ADDR_WIDTH+1:2]. Higher address bits are ignored, so addresses wrap modulo 4*2**ADDR_WIDTH bytes.
- Byte offset off = addr[1:0].
- Store lane mask:
  - funct3 000: byte lane off gets memory_write[7:0].
  - funct3 001: lanes off, off+1 get memory_write[15:0].
  - funct3 010: all four lanes get memory_write.
  - Unwritten lanes are preserved.
- Load data = stored word >> (8*off), then masked:
  - bytes (000/100) to [7:0], halves (001/101) to [15:0], words (010) unmasked.
  - The remaining upper bits are 0.
- Illegal funct3 rejected with resp_error=1, memory_read_value=0, no array change:
  - loads: 011, 110, 111.
  - stores: any funct3 other than 000/001/010.
- memory_read_value holds its last value until the next response. resp_error is valid only with resp_valid and is 0 otherwise.
- req_valid while req_ready=0 is ignored. The requester must hold the request until it is captured.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined: a half access with off==3, or a word access with off!=0, is rejected: resp_error=1, no write, memory_read_value=0.
- Undefined: misaligned accesses are force-aligned before use. Halves use off[1] only (off&2); words use off=0. resp_error then reflects only illegal funct3.

Test Plan:
- Reset then word store/load, WAIT_CYCLES=0: store 0xDEADBEEF to 0x10, then load word at 0x10 -> resp_valid one cycle after each capture, memory_read_value=0xDEADBEEF, resp_error=0.
- Byte/half lane merge: word 0x11223344 at 0x20; SB 0xFFFFFFAA at 0x21; SH 0x0000BEEF at 0x22; LW 0x20 -> 0xBEEFAA44. LB 0x21 -> 0x000000AA. LH 0x22 -> 0x0000BEEF.
- Wait states, WAIT_CYCLES=3: capture at cycle 0 -> req_ready low in cycles 1-4, resp_valid only in cycle 4, next capture possible on edge ending cycle 5. req_valid pulses in cycles 1-4 are ignored.
- Wrap and illegal funct3, ADDR_WIDTH=10: SW 0x55 at 0x1000, then LW 0x0000 -> 0x00000055. LW with funct3=011 -> resp_error=1, data 0, array unchanged.
- Misalignment: LW 0x22 with word 0xCAFEF00D at 0x20.
  - MISALIGN_TRAP_EN defined: resp_error=1, value 0.
  - Undefined: value 0xCAFEF00D, resp_error=0.
  - SW 0x01020304 to 0x23 with trap: word unchanged.
- Reset mid-operation, WAIT_CYCLES=2: capture SW 0x12345678 to 0x30, assert reset in cycle 1 -> no resp_valid, req_ready=1 after reset. A following LW 0x30 returns the prior contents.

Source files
------------

// File: rtl/memory_responder.sv
// Data-memory responder: captures one load/store request per handshake, commits it after WAIT_CYCLES wait states.
// Latency: resp_valid is high in the (WAIT_CYCLES+1)th cycle after the capture edge.
// Backpressure: req_ready is low from capture through the response cycle. Optional macro MISALIGN_TRAP_EN rejects misaligned half/word accesses.
module memory_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        memory_write_en,
  input  logic [2:0]  memory_funct3,
  input  logic [31:0] memory_read_address,
  input  logic [31:0] memory_write_address,
  input  logic [31:0] memory_write,
  output logic        resp_valid,
  output logic [31:0] memory_read_value,
  output logic        resp_error
);

  localparam int AW = ADDR_WIDTH + 2;
  localparam logic [3:0] WAIT_LD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     wdat_q, wdat_d;
  logic            ready_q, ready_d;
  logic            rvld_q, rvld_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [31:0] mem [0:(2**ADDR_WIDTH)-1];

  // Address bits above the array size wrap and are deliberately ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{memory_read_address[31:AW], memory_write_address[31:AW]};

  logic                  idle;
  logic                  capture;
  logic                  op_we;
  logic [2:0]            op_f3;
  logic [AW-1:0]         op_addr;
  logic [31:0]           op_wdat;
  logic [ADDR_WIDTH-1:0] idx;
  logic [1:0]            off;
  logic [1:0]            eff_off;
  logic                  is_byte, is_half, is_word;
  logic                  legal, misal, op_err;
  logic [31:0]           old_word, shifted, load_val, wshift;
  logic [3:0]            lane_mask, be;
  logic                  commit;

  assign idle    = (state_q == ST_IDLE);
  assign capture = req_valid && ready_q;

  // The operation being decoded is the live request when idle (zero-wait commit on the capture edge), otherwise the captured one.
  always_comb begin
    op_we   = we_q;
    op_f3   = f3_q;
    op_addr = addr_q;
    op_wdat = wdat_q;
    if (idle) begin
      op_we   = memory_write_en;
      op_f3   = memory_funct3;
      op_addr = memory_write_en ? memory_write_address[AW-1:0] : memory_read_address[AW-1:0];
      op_wdat = memory_write;
    end
  end

  // Decode size, legality, alignment, byte lanes and the shifted load value.
  always_comb begin
    idx     = op_addr[AW-1:2];
    off     = op_addr[1:0];
    is_byte = (op_f3[1:0] == 2'b00);
    is_half = (op_f3[1:0] == 2'b01);
    is_word = (op_f3 == 3'b010);
    if (op_we) legal = (op_f3 == 3'b000) || (op_f3 == 3'b001) || (op_f3 == 3'b010);
    else       legal = (op_f3 == 3'b000) || (op_f3 == 3'b001) || (op_f3 == 3'b010) ||
                       (op_f3 == 3'b100) || (op_f3 == 3'b101);
`ifdef MISALIGN_TRAP_EN
    eff_off = off;
    misal   = (is_half && (off == 2'd3)) || (is_word && (off != 2'd0));
`else
    // Misaligned halves snap to the even half, words to the word boundary.
    eff_off = is_word ? 2'd0 : (is_half ? {off[1], 1'b0} : off);
    misal   = 1'b0;
`endif
    op_err   = !legal || misal;
    old_word = mem[idx];
    shifted  = old_word >> {eff_off, 3'b000};
    if (is_byte)      load_val = {24'd0, shifted[7:0]};
    else if (is_half) load_val = {16'd0, shifted[15:0]};
    else              load_val = shifted;
    if (is_byte)      lane_mask = 4'b0001 << eff_off;
    else if (is_half) lane_mask = 4'b0011 << eff_off;
    else              lane_mask = 4'b1111;
    be     = (op_we && !op_err) ? lane_mask : 4'b0000;
    wshift = op_wdat << {eff_off, 3'b000};
  end

  // Commit happens on the edge entering RESP; a reset on that edge cancels it.
  assign commit = !reset &&
                  ((idle && capture && (WAIT_CYCLES == 0)) ||
                   ((state_q == ST_WAIT) && (cnt_q == 4'd0)));

  // Byte-lane store into the array; unwritten lanes keep their contents.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wshift[8*b +: 8];
      end
    end
  end

  // Next-state and registered-output computation for the IDLE/WAIT/RESP sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    ready_d = ready_q;
    rvld_d  = 1'b0;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (capture) begin
          we_d    = op_we;
          f3_d    = op_f3;
          addr_d  = op_addr;
          wdat_d  = op_wdat;
          ready_d = 1'b0;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
            rvld_d  = 1'b1;
            err_d   = op_err;
            rdata_d = op_err ? 32'd0 : load_val;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          rvld_d  = 1'b1;
          err_d   = op_err;
          rdata_d = op_err ? 32'd0 : load_val;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous reset; reset abandons any pending request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdat_q  <= 32'd0;
      ready_q <= 1'b1;
      rvld_q  <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      ready_q <= ready_d;
      rvld_q  <= rvld_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready         = ready_q;
  assign resp_valid        = rvld_q;
  assign memory_read_value = rdata_q;
  assign resp_error        = err_q;

endmodule
